// File: rtl/async_fifo_wfull_pkg.sv
// Shared async FIFO definitions: default sizing and the gray-to-binary helper.
// The read-side empty stage imports this package too.
package async_fifo_wfull_pkg;

  localparam int unsigned DEF_ADDR_SIZE   = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_AF_MARGIN   = 2;

  // Zero-extended gray input: the leading zeros leave the prefix XOR unchanged,
  // so one fixed-width function serves every pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin     = '0;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_wfull_ptr_sync.sv
// Multi-flop synchroniser for a gray pointer crossing into the clk domain.
// Shared by the write-side full stage and the read-side empty stage.
module async_fifo_ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_wfull.sv
// Write-domain full-flag stage of the async FIFO: synchronises the read pointer and registers full.
// Define ASYNC_FIFO_ALMOST_FULL_EN to add the registered almost_full flag and wr_level occupancy.
module async_fifo_wfull
  import async_fifo_wfull_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned AF_MARGIN   = DEF_AF_MARGIN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_SIZE:0] wgray_next,
  input  logic [ADDR_SIZE:0] rgray_async,
  output logic [ADDR_SIZE:0] rgray_sync,
  output logic               full,
  output logic               not_full
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  ,
  output logic               almost_full,
  output logic [ADDR_SIZE:0] wr_level
`endif
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  if (ADDR_SIZE < 2 || SYNC_STAGES < 2 || AF_MARGIN > (2 ** ADDR_SIZE)) begin : g_bad_param
    $error("async_fifo_wfull: illegal parameter combination");
  end

  async_fifo_ptr_sync #(
    .WIDTH      (PW),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rptr_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rgray_async),
    .q    (rgray_sync)
  );

  // Full when the writer is exactly one lap ahead: top two gray bits inverted, rest equal.
  logic [PW-1:0] full_ptr;
  logic          full_d;
  logic          full_q;

  always_comb begin
    full_ptr = {~rgray_sync[ADDR_SIZE -: 2], rgray_sync[ADDR_SIZE-2:0]};
    full_d   = (wgray_next == full_ptr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign full     = full_q;
  assign not_full = ~full_q;

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'((2 ** ADDR_SIZE) - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_d;
  logic [PW-1:0] level_q;
  logic          af_d;
  logic          af_q;

  always_comb begin
    wbin    = PW'(gray2bin(32'(wgray_next)));
    rbin    = PW'(gray2bin(32'(rgray_sync)));
    level_d = wbin - rbin;
    af_d    = (level_d >= AF_THRESH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign wr_level    = level_q;
  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_async_fifo_wfull.sv
// Self-checking bench for async_fifo_wfull against a pointer-count reference model.
// Define ASYNC_FIFO_ALMOST_FULL_EN to also exercise almost_full / wr_level.
module tb_async_fifo_wfull;

  localparam int A     = 4;
  localparam int SYNC  = 2;
  localparam int AFM   = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] wgray_next;
  logic [4:0] rgray_async;
  logic [4:0] rgray_sync;
  logic       full;
  logic       not_full;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  logic       almost_full;
  logic [4:0] wr_level;
`endif

  async_fifo_wfull #(
    .ADDR_SIZE  (A),
    .SYNC_STAGES(SYNC),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wgray_next (wgray_next),
    .rgray_async(rgray_async),
    .rgray_sync (rgray_sync),
    .full       (full),
    .not_full   (not_full)
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full),
    .wr_level   (wr_level)
`endif
  );

  always #10 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  // Model: wb/rb are absolute write/read counts; hist holds the read count seen at each edge.
  int   wb;
  int   rb;
  int   hist[$];
  logic exp_full;
  int   exp_level;
  int   exp_rsync;

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b & 31);
    return v ^ (v >> 1);
  endfunction

  task automatic drive();
    wgray_next  = g(wb);
    rgray_async = g(rb);
  endtask

  task automatic reset_model();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
    wb = 0;
    rb = 0;
    exp_full  = 1'b0;
    exp_level = 0;
    exp_rsync = 0;
    drive();
  endtask

  // Advance one edge; expectations are occupancy seen through a SYNC-edge-old read count.
  task automatic tick();
    int rs_prev;
    int diff;
    rs_prev   = hist[hist.size() - SYNC];
    diff      = (wb - rs_prev) & 31;
    exp_full  = (diff == DEPTH);
    exp_level = diff;
    @(posedge clk);
    hist.push_back(rb);
    if (hist.size() > 8) void'(hist.pop_front());
    exp_rsync = hist[hist.size() - SYNC];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    reset_model();
    #3;
    checks++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++;
    if (not_full !== 1'b1) begin failures++; $display("FAIL reset_not_full: got %b expected 1", not_full); end
    checks++;
    if (rgray_sync !== 5'b00000) begin failures++; $display("FAIL reset_rsync: got %b expected 00000", rgray_sync); end
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    checks++;
    if (almost_full !== 1'b0 || wr_level !== 5'd0) begin
      failures++; $display("FAIL reset_af: got af=%b level=%0d expected 0/0", almost_full, wr_level);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int b = 1; b <= 16; b++) begin
      wb = b;
      drive();
      tick();
      checks++;
      if (full !== exp_full) begin failures++; $display("FAIL fill_full w=%0d: got %b expected %b", b, full, exp_full); end
      if (b == 15) begin
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL fill_before_edge: got %b expected 0", full); end
      end
      if (b == 16) begin
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full_edge: got %b expected 1", full); end
      end
    end
  endtask

  task automatic test_hold();
    logic [4:0] held;
    held = wgray_next;
    for (int i = 0; i < 20; i++) begin
      if (not_full) wb++;
      drive();
      tick();
      checks++;
      if (full !== 1'b1) begin failures++; $display("FAIL hold_full cyc=%0d: got %b expected 1", i, full); end
      checks++;
      if (wgray_next !== held) begin failures++; $display("FAIL hold_wptr cyc=%0d: got %b expected %b", i, wgray_next, held); end
    end
  endtask

  task automatic test_read_release();
    rb = 1;
    drive();
    tick();
    checks++;
    if (rgray_sync !== 5'b00000 || full !== 1'b1) begin
      failures++; $display("FAIL release_e1: got rsync=%b full=%b expected 00000/1", rgray_sync, full);
    end
    tick();
    checks++;
    if (rgray_sync !== 5'b00001 || full !== 1'b1) begin
      failures++; $display("FAIL release_e2: got rsync=%b full=%b expected 00001/1", rgray_sync, full);
    end
    tick();
    checks++;
    if (full !== 1'b0 || not_full !== 1'b1) begin
      failures++; $display("FAIL release_e3: got full=%b not_full=%b expected 0/1", full, not_full);
    end
  endtask

  task automatic test_reset_mid();
    wb = 17;
    drive();
    tick();
    checks++;
    if (full !== 1'b1) begin failures++; $display("FAIL refill_full: got %b expected 1", full); end
    #8;
    reset = 1'b1;
    #1;
    checks++;
    if (full !== 1'b0 || not_full !== 1'b1) begin
      failures++; $display("FAIL midreset_full: got full=%b not_full=%b expected 0/1", full, not_full);
    end
    checks++;
    if (rgray_sync !== 5'b00000) begin failures++; $display("FAIL midreset_rsync: got %b expected 00000", rgray_sync); end
    reset_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      if (not_full && wb < 16) wb++;
      drive();
      tick();
      checks++;
      if (full !== exp_full) begin failures++; $display("FAIL wrap_fill cyc=%0d: got %b expected %b", i, full, exp_full); end
    end
    for (int i = 0; i < 16; i++) begin
      rb++;
      drive();
      tick();
      checks++;
      if (full !== exp_full || rgray_sync !== g(exp_rsync)) begin
        failures++; $display("FAIL wrap_read cyc=%0d: got full=%b rsync=%b expected %b/%b", i, full, rgray_sync, exp_full, g(exp_rsync));
      end
    end
    for (int i = 0; i < 24; i++) begin
      if (not_full && wb < 32) wb++;
      drive();
      tick();
      checks++;
      if (full !== exp_full) begin failures++; $display("FAIL wrap_write cyc=%0d: got %b expected %b", i, full, exp_full); end
    end
    checks++;
    if (rgray_sync !== 5'b11000) begin failures++; $display("FAIL wrap_rsync: got %b expected 11000", rgray_sync); end
    checks++;
    if (wb != 32 || full !== 1'b1) begin
      failures++; $display("FAIL wrap_full: got wcount=%0d full=%b expected 32/1", wb, full);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (not_full && $urandom_range(0, 1) == 1) wb++;
      if (rb < wb && $urandom_range(0, 2) == 0) rb++;
      drive();
      tick();
      checks++;
      if (full !== exp_full || not_full !== ~exp_full) begin
        failures++; $display("FAIL rand_full cyc=%0d: got full=%b not_full=%b expected full=%b", i, full, not_full, exp_full);
      end
      checks++;
      if (rgray_sync !== g(exp_rsync)) begin
        failures++; $display("FAIL rand_rsync cyc=%0d: got %b expected %b", i, rgray_sync, g(exp_rsync));
      end
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
      checks++;
      if (wr_level !== 5'(exp_level) || almost_full !== (exp_level >= DEPTH - AFM)) begin
        failures++; $display("FAIL rand_level cyc=%0d: got level=%0d af=%b expected %0d", i, wr_level, almost_full, exp_level);
      end
`endif
    end
  endtask

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    #8;
    reset = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int b = 1; b <= 14; b++) begin
      wb = b;
      drive();
      tick();
      checks++;
      if (wr_level !== 5'(exp_level) || almost_full !== (exp_level >= DEPTH - AFM)) begin
        failures++; $display("FAIL af_step w=%0d: got level=%0d af=%b expected %0d", b, wr_level, almost_full, exp_level);
      end
      if (b == 13) begin
        checks++;
        if (wr_level !== 5'd13 || almost_full !== 1'b0) begin
          failures++; $display("FAIL af_13: got level=%0d af=%b expected 13/0", wr_level, almost_full);
        end
      end
      if (b == 14) begin
        checks++;
        if (wr_level !== 5'd14 || almost_full !== 1'b1) begin
          failures++; $display("FAIL af_14: got level=%0d af=%b expected 14/1", wr_level, almost_full);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_read_release();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
